// File: rtl/noc_injector.sv
// Packetizing injection interface: turns a send request plus a payload word stream into HEADER/BODY/TAIL wormhole flits.
// Latency: request accepted at edge E puts HEADER on the link in cycle E+1; each accepted word appears as a flit one cycle later.
// Backpressure: the output flit register holds under ack=0; payload is pulled only when that register is empty or draining this edge.

package noc_injector_pkg;
  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 32;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } addr_t;

  // BODY is the all-zero encoding so the idle bus is a plain zero word.
  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEADER = 2'b01,
    TAIL   = 2'b10
  } flit_type_t;

  typedef struct packed {
    addr_t                                dst_addr;
    logic [PAYLOAD_W-$bits(addr_t)-1:0]   rsvd;
  } flit_hdr_t;

  typedef struct packed {
    flit_type_t             flit_type;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  localparam int ADDR_W = $bits(addr_t);
  localparam int FLIT_W = $bits(flit_t);
endpackage

module noc_injector
  import noc_injector_pkg::*;
#(
  parameter int  X       = 1,
  parameter int  Y       = 1,
  parameter int  MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_dst,
  input  logic [LEN_W-1:0]     req_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [PAYLOAD_W-1:0] data,
  output logic [FLIT_W-1:0]    out_flit,
  output logic                 out_enable,
  input  logic                 out_ack,
  output logic                 pkt_done,
  output logic                 err_self
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DONE
  } state_t;

  localparam addr_t OWN_ADDR = '{x: COORD_W'(X), y: COORD_W'(Y)};
  localparam flit_t IDLE_FLIT = '{flit_type: BODY, payload: '0};
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  flit_t            flit_q;
  logic             flit_vld_q;
  logic             err_q;
  logic             done_q;

  logic             xfer;
  logic             can_load;
  logic             load;
  flit_t            load_flit;
  logic             self_hit;
  logic [LEN_W-1:0] len_sat;
  flit_hdr_t        hdr;

  // The current flit leaves on this edge; the register may take a new one when empty or draining.
  assign xfer     = flit_vld_q && out_ack;
  assign can_load = !flit_vld_q || xfer;
  assign len_sat  = (req_len > LEN_MAX) ? LEN_MAX : req_len;

  // Next-state, handshakes and the flit to load; payload consumption is shared by HDR and DATA.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    load        = 1'b0;
    load_flit   = IDLE_FLIT;
    req_ready   = 1'b0;
    data_ready  = 1'b0;
    self_hit    = 1'b0;
    hdr         = '0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          remaining_d = len_sat;
          if (addr_t'(req_dst) == OWN_ADDR) begin
            self_hit = 1'b1;
          end else begin
            hdr.dst_addr        = addr_t'(req_dst);
            load                = 1'b1;
            load_flit.flit_type = HEADER;
            load_flit.payload   = hdr;
            state_d             = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (remaining_q == '0) begin
            load                = 1'b1;
            load_flit.flit_type = TAIL;
            load_flit.payload   = '0;
            state_d             = S_DONE;
          end else begin
            // Pull the first word on the HEADER's own transfer edge to keep 1 flit/cycle.
            data_ready = 1'b1;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        data_ready = can_load;
      end
      S_DONE: begin
        if (xfer) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (data_ready && data_valid) begin
      load              = 1'b1;
      load_flit.payload = data;
      remaining_d       = remaining_q - LEN_ONE;
      if (remaining_q > LEN_ONE) begin
        load_flit.flit_type = BODY;
      end else begin
        load_flit.flit_type = TAIL;
        state_d             = S_DONE;
      end
    end
  end

  // Control state and outstanding word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Output flit register; when it drains without a refill the bus falls back to an idle BODY word.
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_vld_q <= 1'b0;
      flit_q     <= IDLE_FLIT;
    end else if (load) begin
      flit_vld_q <= 1'b1;
      flit_q     <= load_flit;
    end else if (xfer) begin
      flit_vld_q <= 1'b0;
      flit_q     <= IDLE_FLIT;
    end
  end

  // One-cycle status pulses, registered so they follow the triggering edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      err_q  <= self_hit;
      done_q <= (state_q == S_DONE) && xfer;
    end
  end

  assign out_flit   = flit_q;
  assign out_enable = flit_vld_q;
  assign pkt_done   = done_q;
  assign err_self   = err_q;

endmodule
